control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle main control unit of the processor datapath, directly upstream of the ALU controller. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the 6-bit ALU operation code consumed by the ALU controller. It also drives all datapath enables: PC, IR, register file, stack pointer and memory request. A single-slave memory handshake stalls the sequence on slow memory.

## Interface
- `OPW`, default 6: opcode / ALU-op width.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  OPW: IR[31:26], valid from DECODE onward.
- `flag_n`, `flag_z`  in  1 each: registered ALU flags from the previous ALU instruction.
- `mem_ready`  in  1: memory completes the current request this cycle.
- `alu_op`  out  OPW: ALU-op code to the ALU controller.
- `ir_write`, `pc_write`, `reg_write`  out  1 each: datapath register enables.
- `pc_src`  out  2: 0 = PC+4, 1 = ALU result, 2 = memory data.
- `wb_src`  out  1: 0 = ALU, 1 = memory data.
- `mem_req`, `mem_we`  out  1 each: memory request and write qualifier.
- `addr_src`  out  2: 0 = PC, 1 = ALU, 2 = SP.
- `sp_inc`, `sp_dec`  out  1 each: stack-pointer update (±4).
- `halted`  out  1: in HALT state.
- `illegal`  out  1: one-cycle pulse on an undefined opcode.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Registered state; outputs are Moore, decoded from state and registered opcode.
- Opcode map (hex): 00 R-type, 01–09 I-type ALU, 0A LD, 0B ST, 0C LDSP, 0D STSP, 0E BR, 0F BMI, 10 BPL, 11 BZ, 12 PUSH, 13 POP, 14 CALL, 15 RET, 16 MOVE, 20 HALT.
- FETCH: `mem_req`=1, `addr_src`=0. Stays until `mem_ready`. On that cycle, `ir_write`=1, `pc_write`=1, `pc_src`=0; next state is DECODE.
- DECODE: HALT → HALT. Undefined → `illegal`=1, then FETCH. All others → EXEC.
- EXEC: `alu_op`=opcode for 00–0E; 3F otherwise.
  - ALU types and MOVE → WB.
  - LD, ST, LDSP, STSP → MEM with `addr_src`=1.
  - BR: `pc_write`=1, `pc_src`=1 → FETCH.
  - BMI / BPL / BZ: `pc_write`=1, `pc_src`=1 only if `flag_n` / !`flag_n` / `flag_z` → FETCH.
  - PUSH, CALL: `sp_dec`=1 → MEM.
  - POP, RET → MEM.
- MEM: `mem_req`=1 until `mem_ready`. Stores, PUSH and CALL use `mem_we`=1. PUSH, CALL, POP and RET use `addr_src`=2.
  - On `mem_ready`: LD, LDSP, POP → WB.
  - RET: `pc_write`=1, `pc_src`=2, `sp_inc`=1 → FETCH.
  - CALL: `pc_write`=1, `pc_src`=1 → FETCH.
  - Others → FETCH.
- WB: `reg_write`=1. `wb_src`=1 for loads and POP, else 0. POP also asserts `sp_inc`. Next state is FETCH.
- HALT: absorbing; only `rst_n` leaves it. `halted`=1, all enables 0.
- `alu_op` outside EXEC = 3F. All enables default to 0.

## Timing
- Reset (async assert, sync release): state = FETCH. `alu_op`=3F, all enables 0, `halted`=0, `illegal`=0. First `mem_req` is in the first cycle after release.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - ALU / MOVE: 4 cycles.
  - LD / POP: 5 cycles.
  - ST / PUSH / CALL / RET: 4 cycles.
  - Branches: 3 cycles.
- Each cycle `mem_ready` is low adds exactly one cycle. While stalled, `mem_req`, `mem_we` and `addr_src` are held stable.
- `mem_ready` is ignored outside FETCH/MEM.
- `sp_dec` and the PC update fire once per instruction, never repeated during stalls.
- Reset asserted mid-instruction: immediate return to reset values. A pending memory request is dropped with no write enable.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants, also used by the ALU controller;
  - `ALUOP_NOP` = 3F;
  - state enum;
  - `pc_src`, `addr_src` and `wb_src` encodings.
- One natural sub-module, `cond_eval`: combinational branch-condition check from opcode and flags.

## Test plan
- Reset mid-MEM of ST with `mem_req`=1 → next cycle state FETCH, `mem_we`=0, `alu_op`=3F.
- ADDI (01), `mem_ready`=1 → `alu_op`=01 in EXEC only, `reg_write` on cycle 4, `wb_src`=0.
- LD (0A) with `mem_ready` low 3 cycles in MEM → 8 total cycles; `mem_req` steady, then `reg_write` with `wb_src`=1.
- BZ (11): `flag_z`=1 → `pc_write`=1, `pc_src`=1 in EXEC; `flag_z`=0 → no `pc_write`. Both take 3 cycles.
- CALL (14) → `sp_dec` in EXEC; MEM with `mem_we`=1, `addr_src`=2; `pc_write` with `pc_src`=1. RET (15) → `sp_inc` and `pc_src`=2.
- Opcode 3A → `illegal` pulse in DECODE, back to FETCH. HALT (20) → `halted`=1 held for 100 cycles, `mem_req`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ALU-op idle code, control FSM state
// encoding and datapath mux select encodings.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_ITYPE_H = 6'h09;
  localparam logic [5:0] OP_LD      = 6'h0A;
  localparam logic [5:0] OP_ST      = 6'h0B;
  localparam logic [5:0] OP_LDSP    = 6'h0C;
  localparam logic [5:0] OP_STSP    = 6'h0D;
  localparam logic [5:0] OP_BR      = 6'h0E;
  localparam logic [5:0] OP_BMI     = 6'h0F;
  localparam logic [5:0] OP_BPL     = 6'h10;
  localparam logic [5:0] OP_BZ      = 6'h11;
  localparam logic [5:0] OP_PUSH    = 6'h12;
  localparam logic [5:0] OP_POP     = 6'h13;
  localparam logic [5:0] OP_CALL    = 6'h14;
  localparam logic [5:0] OP_RET     = 6'h15;
  localparam logic [5:0] OP_MOVE    = 6'h16;
  localparam logic [5:0] OP_HALT    = 6'h20;

  // Opcodes up to and including BR are passed to the ALU controller verbatim.
  localparam logic [5:0] ALUOP_LAST = 6'h0E;
  localparam logic [5:0] ALUOP_NOP  = 6'h3F;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] PC_SRC_PC4   = 2'd0;
  localparam logic [1:0] PC_SRC_ALU   = 2'd1;
  localparam logic [1:0] PC_SRC_MEM   = 2'd2;
  localparam logic [1:0] ADDR_SRC_PC  = 2'd0;
  localparam logic [1:0] ADDR_SRC_ALU = 2'd1;
  localparam logic [1:0] ADDR_SRC_SP  = 2'd2;
  localparam logic       WB_SRC_ALU   = 1'b0;
  localparam logic       WB_SRC_MEM   = 1'b1;

  function automatic logic op_defined(input logic [5:0] op);
    return (op <= OP_MOVE) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch-condition check: high when the opcode is a branch whose condition
// holds for the current registered ALU flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic       flag_n,
  input  logic       flag_z,
  output logic       take
);

  always_comb begin
    case (op)
      OP_BR:   take = 1'b1;
      OP_BMI:  take = flag_n;
      OP_BPL:  take = !flag_n;
      OP_BZ:   take = flag_z;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the ALU-op code and all datapath enables, stalling on mem_ready.
//
// state     | meaning
// ST_FETCH  | instruction read at PC; IR and PC+4 load on mem_ready
// ST_DECODE | opcode classified; undefined opcode pulses illegal
// ST_EXEC   | ALU operation, address calc, branch resolve, SP pre-decrement
// ST_MEM    | data memory access; CALL/RET update PC on completion
// ST_WB     | register file write from ALU or memory data
// ST_HALT   | absorbing stop state; only reset leaves it
module control_fsm
  import cpu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           flag_n,
  input  logic           flag_z,
  input  logic           mem_ready,
  output logic [OPW-1:0] alu_op,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic [1:0]     pc_src,
  output logic           wb_src,
  output logic           mem_req,
  output logic           mem_we,
  output logic [1:0]     addr_src,
  output logic           sp_inc,
  output logic           sp_dec,
  output logic           halted,
  output logic           illegal
);

  state_t     state, state_nxt;
  logic [5:0] op;
  logic       take;
  logic       is_alu, is_ls, is_stack, is_store, is_load, is_branch;

  assign op        = 6'(opcode);
  assign is_alu    = (op <= OP_ITYPE_H) || (op == OP_MOVE);
  assign is_ls     = (op == OP_LD) || (op == OP_ST) || (op == OP_LDSP) || (op == OP_STSP);
  assign is_stack  = (op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);
  assign is_store  = (op == OP_ST) || (op == OP_STSP) || (op == OP_PUSH) || (op == OP_CALL);
  assign is_load   = (op == OP_LD) || (op == OP_LDSP) || (op == OP_POP);
  assign is_branch = (op == OP_BR) || (op == OP_BMI) || (op == OP_BPL) || (op == OP_BZ);

  cond_eval u_cond_eval (
    .op     (op),
    .flag_n (flag_n),
    .flag_z (flag_z),
    .take   (take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_HALT)        state_nxt = ST_HALT;
        else if (!op_defined(op)) state_nxt = ST_FETCH;
        else                      state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu)                 state_nxt = ST_WB;
        else if (is_ls || is_stack) state_nxt = ST_MEM;
        else                        state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        if (mem_ready) state_nxt = is_load ? ST_WB : ST_FETCH;
      end
      ST_WB:   state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Outputs are forced to reset values while rst_n is low so a pending
  // memory request is dropped immediately, not at the next edge.
  always_comb begin
    alu_op    = OPW'(ALUOP_NOP);
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_src    = PC_SRC_PC4;
    wb_src    = WB_SRC_ALU;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = ADDR_SRC_PC;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: illegal = !op_defined(op);
        ST_EXEC: begin
          if (op <= ALUOP_LAST) alu_op = OPW'(op);
          if (is_ls) addr_src = ADDR_SRC_ALU;
          if (is_branch && take) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALU;
          end
          sp_dec = (op == OP_PUSH) || (op == OP_CALL);
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          mem_we   = is_store;
          addr_src = is_stack ? ADDR_SRC_SP : ADDR_SRC_ALU;
          if (mem_ready && (op == OP_RET)) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_MEM;
            sp_inc   = 1'b1;
          end
          if (mem_ready && (op == OP_CALL)) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_ALU;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_src    = is_load ? WB_SRC_MEM : WB_SRC_ALU;
          sp_inc    = (op == OP_POP);
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm: one record per clock cycle
// with hand-computed outputs, plus reset-mid-store and HALT sequences.
module tb_control_fsm;

  typedef struct packed {
    logic [5:0] alu_op;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] pc_src;
    logic       wb_src, mem_req, mem_we;
    logic [1:0] addr_src;
    logic       sp_inc, sp_dec, halted, illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       fn, fz, rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       flag_n, flag_z, mem_ready;
  logic [5:0] alu_op;
  logic       ir_write, pc_write, reg_write, wb_src, mem_req, mem_we;
  logic [1:0] pc_src, addr_src;
  logic       sp_inc, sp_dec, halted, illegal;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  control_fsm #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flag_n(flag_n), .flag_z(flag_z),
    .mem_ready(mem_ready), .alu_op(alu_op), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .pc_src(pc_src), .wb_src(wb_src), .mem_req(mem_req),
    .mem_we(mem_we), .addr_src(addr_src), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .halted(halted), .illegal(illegal)
  );

  function automatic outs_t mk(input logic [5:0] a, input logic irw, input logic pcw,
                               input logic rw, input logic [1:0] pcs, input logic wbs,
                               input logic mrq, input logic mwe, input logic [1:0] asrc,
                               input logic spi, input logic spd, input logic h,
                               input logic il);
    outs_t o;
    o = '{a, irw, pcw, rw, pcs, wbs, mrq, mwe, asrc, spi, spd, h, il};
    return o;
  endfunction

  function automatic outs_t obs();
    outs_t o;
    o = '{alu_op, ir_write, pc_write, reg_write, pc_src, wb_src, mem_req, mem_we,
          addr_src, sp_inc, sp_dec, halted, illegal};
    return o;
  endfunction

  task automatic check(input outs_t e, input string nm);
    outs_t g;
    g = obs();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (alu_op got %h exp %h)", nm, g, e, g.alu_op, e.alu_op);
    end
  endtask

  task automatic apply(input vec_t v);
    opcode    = v.op;
    flag_n    = v.fn;
    flag_z    = v.fz;
    mem_ready = v.rdy;
    @(negedge clk);
    check(v.exp, v.name);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic fn, input logic fz, input logic rdy,
                     input outs_t e, input string nm);
    vec_t v;
    v = '{op, fn, fz, rdy, e, nm};
    tbl.push_back(v);
  endtask

  outs_t FR, FW, ID, HLT;
  vec_t  v;

  initial begin
    FR  = mk(6'h3F, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    FW  = mk(6'h3F, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    ID  = mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    HLT = mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // ADDI: 4 cycles, alu_op only in EXEC
    add(6'h01, 0, 0, 1, FR, "addi_fetch");
    add(6'h01, 0, 0, 0, ID, "addi_decode");
    add(6'h01, 0, 0, 0, mk(6'h01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_exec");
    add(6'h01, 0, 0, 1, mk(6'h3F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_wb");
    // LD: one fetch wait, three MEM waits
    add(6'h0A, 0, 0, 0, FW, "ld_fetch_wait");
    add(6'h0A, 0, 0, 1, FR, "ld_fetch");
    add(6'h0A, 0, 0, 1, ID, "ld_decode");
    add(6'h0A, 0, 0, 0, mk(6'h0A, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "ld_exec");
    for (int i = 0; i < 3; i++)
      add(6'h0A, 0, 0, 0, mk(6'h3F, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "ld_mem_wait");
    add(6'h0A, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "ld_mem");
    add(6'h0A, 0, 0, 0, mk(6'h3F, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "ld_wb");
    // BZ taken / not taken
    add(6'h11, 0, 1, 1, FR, "bz_t_fetch");
    add(6'h11, 0, 1, 1, ID, "bz_t_decode");
    add(6'h11, 0, 1, 1, mk(6'h3F, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "bz_t_exec");
    add(6'h11, 0, 0, 1, FR, "bz_n_fetch");
    add(6'h11, 0, 0, 1, ID, "bz_n_decode");
    add(6'h11, 0, 0, 1, ID, "bz_n_exec");
    // BMI taken with N set, BPL not taken with N set, BR always
    add(6'h0F, 1, 0, 1, FR, "bmi_fetch");
    add(6'h0F, 1, 0, 0, ID, "bmi_decode");
    add(6'h0F, 1, 0, 0, mk(6'h3F, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "bmi_exec");
    add(6'h10, 1, 0, 1, FR, "bpl_fetch");
    add(6'h10, 1, 0, 1, ID, "bpl_decode");
    add(6'h10, 1, 0, 1, ID, "bpl_exec");
    add(6'h0E, 0, 0, 1, FR, "br_fetch");
    add(6'h0E, 0, 0, 1, ID, "br_decode");
    add(6'h0E, 0, 0, 1, mk(6'h0E, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "br_exec");
    // CALL / RET
    add(6'h14, 0, 0, 1, FR, "call_fetch");
    add(6'h14, 0, 0, 1, ID, "call_decode");
    add(6'h14, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "call_exec");
    add(6'h14, 0, 0, 1, mk(6'h3F, 0, 1, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0), "call_mem");
    add(6'h15, 0, 0, 1, FR, "ret_fetch");
    add(6'h15, 0, 0, 1, ID, "ret_decode");
    add(6'h15, 0, 0, 1, ID, "ret_exec");
    add(6'h15, 0, 0, 1, mk(6'h3F, 0, 1, 0, 2, 0, 1, 0, 2, 1, 0, 0, 0), "ret_mem");
    // PUSH with one MEM stall: sp_dec must not repeat
    add(6'h12, 0, 0, 1, FR, "push_fetch");
    add(6'h12, 0, 0, 1, ID, "push_decode");
    add(6'h12, 0, 0, 0, mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "push_exec");
    add(6'h12, 0, 0, 0, mk(6'h3F, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0), "push_mem_wait");
    add(6'h12, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0), "push_mem");
    // POP
    add(6'h13, 0, 0, 1, FR, "pop_fetch");
    add(6'h13, 0, 0, 1, ID, "pop_decode");
    add(6'h13, 0, 0, 1, ID, "pop_exec");
    add(6'h13, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0), "pop_mem");
    add(6'h13, 0, 0, 1, mk(6'h3F, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0), "pop_wb");
    // LDSP, MOVE
    add(6'h0C, 0, 0, 1, FR, "ldsp_fetch");
    add(6'h0C, 0, 0, 1, ID, "ldsp_decode");
    add(6'h0C, 0, 0, 1, mk(6'h0C, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "ldsp_exec");
    add(6'h0C, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "ldsp_mem");
    add(6'h0C, 0, 0, 1, mk(6'h3F, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "ldsp_wb");
    add(6'h16, 0, 0, 1, FR, "move_fetch");
    add(6'h16, 0, 0, 1, ID, "move_decode");
    add(6'h16, 0, 0, 1, ID, "move_exec");
    add(6'h16, 0, 0, 1, mk(6'h3F, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "move_wb");
    // Undefined opcode: illegal pulse, then back to FETCH
    add(6'h3A, 0, 0, 1, FR, "ill_fetch");
    add(6'h3A, 0, 0, 1, mk(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_decode");
    add(6'h3A, 0, 0, 0, FW, "ill_refetch");

    rst_n = 1'b0; opcode = 6'h00; flag_n = 1'b0; flag_z = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check(ID, "reset_state");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset while ST is stalled in MEM with the write pending
    v = '{6'h0B, 0, 0, 1, FR, "st_fetch"};                                    apply(v);
    v = '{6'h0B, 0, 0, 1, ID, "st_decode"};                                   apply(v);
    v = '{6'h0B, 0, 0, 0, mk(6'h0B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "st_exec"}; apply(v);
    v = '{6'h0B, 0, 0, 0, mk(6'h3F, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), "st_mem_wait"}; apply(v);
    rst_n = 1'b0;
    #1;
    check(ID, "st_reset_drop");
    @(negedge clk);
    rst_n = 1'b1;
    v = '{6'h0B, 0, 0, 0, FW, "st_reset_refetch"};                            apply(v);

    // HALT is absorbing and keeps every enable low
    v = '{6'h20, 0, 0, 1, FR, "halt_fetch"};                                  apply(v);
    v = '{6'h20, 0, 0, 1, ID, "halt_decode"};                                 apply(v);
    for (int i = 0; i < 100; i++) begin
      v = '{6'h20, 0, 0, logic'(i % 2), HLT, "halt_hold"};
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
